// File: rtl/phtime_sched_pkg.sv
// Shared constants and FSM encoding for the phase-time generator scheduler.
package phtime_pkg;
  localparam int FREQW = 27;
  localparam int PHLAT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/phtime_sched_if.sv
// Requester bus plus generator-side signals of the phase-time scheduler.
interface phtime_sched_if #(parameter int NREQ = 4);
  import phtime_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*FREQW-1:0] req_freq;
  logic [NREQ-1:0]       req_ready;
  logic [FREQW-1:0]      ph_freq;
  logic                  ph_reset;
  logic                  ph_valid;
  logic                  busy;
  logic [2:0]            owner;
  logic                  done;
  logic                  timeout_err;

  modport slave (
    input  req_valid, req_freq, ph_valid,
    output req_ready, ph_freq, ph_reset, busy, owner, done, timeout_err
  );

  modport master (
    output req_valid, req_freq, ph_valid,
    input  req_ready, ph_freq, ph_reset, busy, owner, done, timeout_err
  );
endinterface

// File: rtl/phtime_sched_rr_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [2:0]      o_gidx
);
  localparam logic [3:0] NQ = 4'(NREQ);

  logic [NREQ-1:0] w_rot;
  logic [2:0]      w_off;
  logic [3:0]      w_sum;

  always_comb begin
    // Rotate so bit 0 is the requester at ptr; lowest set bit is the winner offset.
    w_rot = NREQ'({i_req, i_req} >> i_ptr);
    w_off = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (w_rot[k]) w_off = 3'(k);
    w_sum  = {1'b0, i_ptr} + {1'b0, w_off};
    o_gidx = (w_sum >= NQ) ? 3'(w_sum - NQ) : w_sum[2:0];
    o_gnt  = (|i_req) ? (NREQ'(1) << o_gidx) : '0;
  end
endmodule

// File: rtl/phtime_sched.sv
// Round-robin scheduler loading one shared phase-time generator, pulsing its
// reset and waiting for its valid flag before signalling done.
module phtime_sched
  import phtime_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int RSTCYC  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  phtime_sched_if.slave bus
);
  localparam int CNTMAX = (RSTCYC > TIMEOUT) ? RSTCYC : TIMEOUT;
  localparam int CNTW   = $clog2(CNTMAX) + 1;
  localparam logic [CNTW-1:0] RSTLAST = CNTW'(RSTCYC - 1);
  localparam logic [CNTW-1:0] TOLAST  = CNTW'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNTW-1:0]  r_cnt;
  logic [2:0]       r_rr;
  logic [2:0]       r_owner;
  logic [FREQW-1:0] r_ph_freq;
  logic             r_ph_reset;
  logic             r_terr;

  logic [NREQ-1:0]  w_gnt;
  logic [2:0]       w_gidx;
  logic             w_acc;
  logic [FREQW-1:0] w_or [NREQ+1];

  rr_arb #(.NREQ(NREQ)) u_arb (
    .i_req  (bus.req_valid),
    .i_ptr  (r_rr),
    .o_gnt  (w_gnt),
    .o_gidx (w_gidx)
  );

  // One-hot grant selects the winning frequency word via an AND-OR chain.
  assign w_or[0] = '0;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fsel
    assign w_or[gi+1] = w_or[gi] |
                        ({FREQW{w_gnt[gi]}} & bus.req_freq[gi*FREQW +: FREQW]);
  end

  assign w_acc = (r_state == IDLE) && i_resetn && (|bus.req_valid);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rr       <= '0;
      r_owner    <= '0;
      r_ph_freq  <= '0;
      r_ph_reset <= 1'b1;
      r_terr     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ph_reset <= 1'b0;
          if (w_acc) begin
            r_ph_freq  <= w_or[NREQ];
            r_owner    <= w_gidx;
            r_rr       <= (w_gidx == 3'(NREQ-1)) ? 3'd0 : w_gidx + 3'd1;
            r_terr     <= 1'b0;
            r_cnt      <= '0;
            r_ph_reset <= 1'b1;
            r_state    <= RST;
          end
        end
        RST: begin
          if (r_cnt == RSTLAST) begin
            r_cnt      <= '0;
            r_ph_reset <= 1'b0;
            r_state    <= WAIT;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        WAIT: begin
          // First WAIT cycle may still show valid from before the reset pulse.
          if (r_cnt != '0 && bus.ph_valid) begin
            r_state <= DONE;
          end else if (r_cnt == TOLAST) begin
            r_terr  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = w_acc ? w_gnt : '0;
  assign bus.ph_freq     = r_ph_freq;
  assign bus.ph_reset    = r_ph_reset;
  assign bus.busy        = (r_state != IDLE);
  assign bus.owner       = r_owner;
  assign bus.done        = (r_state == DONE);
  assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_phtime_sched.sv
// Scoreboard bench for phtime_sched with a behavioural phase-time generator.
module tb_phtime_sched;
  import phtime_pkg::*;

  typedef struct {
    int          own;
    logic [26:0] f;
  } sb_t;

  logic clk;
  logic resetn;
  logic gen_hold;
  int   g_cnt;
  logic [26:0] g_phase;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  done_cnt = 0;
  int  acc_log[$];
  sb_t sb[$];

  int          m_rr;
  int          m_g;
  logic [3:0]  m_rv;
  logic [26:0] m_f;

  phtime_sched_if #(.NREQ(4)) bus ();

  phtime_sched #(.NREQ(4), .RSTCYC(2), .TIMEOUT(16)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator: cleared by ph_reset, valid PHLAT cycles later, accumulates phase.
  always @(posedge clk) begin
    if (bus.ph_reset) begin
      g_cnt   <= 0;
      g_phase <= '0;
    end else begin
      if (g_cnt != PHLAT-1) g_cnt <= g_cnt + 1;
      g_phase <= g_phase + bus.ph_freq;
    end
  end
  assign bus.ph_valid = !gen_hold && (g_cnt == PHLAT-1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accept monitor: independent round-robin model, scoreboard push on accept, pop on done.
  always @(negedge clk) begin
    if (!resetn) begin
      sb.delete();
      m_rr = 0;
    end else begin
      if (bus.req_ready != 4'b0) begin
        m_rv = bus.req_valid;
        m_g  = -1;
        for (int k = 0; k < 4; k++)
          for (int j = 0; j < 4; j++)
            if (m_g < 0 && j == (m_rr + k) % 4 && m_rv[j[1:0]]) m_g = j;
        chk("gnt_onehot", 32'($countones(bus.req_ready)), 1);
        chk("gnt_rr", 32'(bus.req_ready), (m_g < 0) ? 0 : (1 << m_g));
        if (m_g >= 0) begin
          m_f = 27'(bus.req_freq >> (27 * m_g));
          sb.push_back('{m_g, m_f});
          acc_log.push_back(m_g);
          m_rr = (m_g + 1) % 4;
        end
      end
      if (bus.done) begin
        done_cnt++;
        chk("sb_depth", 32'(sb.size()), 1);
        if (sb.size() > 0) begin
          chk("sb_owner", 32'(bus.owner), 32'(sb[0].own));
          chk("sb_freq", 32'(bus.ph_freq), 32'(sb[0].f));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for the accept of requester idx, then drops its request.
  task automatic wait_acc(input logic [1:0] idx);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready[idx] || n >= 60) break;
      n++;
    end
    chk("acc_seen", 32'(bus.req_ready[idx]), 1);
    @(posedge clk);
    #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 60) begin
      step(1);
      n++;
    end
    chk("done_seen", 32'(bus.done), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 60) begin
      step(1);
      n++;
    end
    chk("idle", 32'(bus.busy), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dc, n;
    logic [26:0] p0, p1;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    resetn        = 1'b0;
    gen_hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_freq  = '0;
    step(3);
    chk("rst_freq",  32'(bus.ph_freq), 0);
    chk("rst_phrst", 32'(bus.ph_reset), 1);
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_terr",  32'(bus.timeout_err), 0);
    resetn = 1'b1;
    step(1);
    chk("idle_phrst", 32'(bus.ph_reset), 0);

    // 1: single request, latency of each phase
    bus.req_freq[26:0] = 27'h0123456;
    bus.req_valid[0]   = 1'b1;
    wait_acc(2'd0);
    chk("t1_freq",  32'(bus.ph_freq), 32'h0123456);
    chk("t1_phrst1", 32'(bus.ph_reset), 1);
    chk("t1_owner", 32'(bus.owner), 0);
    step(1);
    chk("t1_phrst2", 32'(bus.ph_reset), 1);
    step(1);
    chk("t1_phrst3", 32'(bus.ph_reset), 0);
    step(3);
    chk("t1_done6", 32'(bus.done), 0);
    step(1);
    chk("t1_done7", 32'(bus.done), 1);
    step(1);
    chk("t1_done8", 32'(bus.done), 0);
    chk("t1_busy8", 32'(bus.busy), 0);

    // 2: all four requesting continuously
    do_reset();
    bus.req_freq[26:0]   = 27'h0100000;
    bus.req_freq[53:27]  = 27'h0200001;
    bus.req_freq[80:54]  = 27'h0300002;
    bus.req_freq[107:81] = 27'h0400003;
    base = acc_log.size();
    dc   = done_cnt;
    bus.req_valid = 4'hF;
    n = 0;
    while (acc_log.size() < base + 5 && n < 200) begin
      step(1);
      n++;
    end
    bus.req_valid = '0;
    wait_idle();
    chk("t2_accs", 32'(acc_log.size() - base), 5);
    for (int k = 0; k < 5; k++)
      if (base + k < acc_log.size())
        chk("t2_order", 32'(acc_log[base+k]), 32'(exp_order[k]));
    chk("t2_dones", 32'(done_cnt - dc), 5);

    // 3: request 2 arrives while 0 is in flight
    bus.req_freq[26:0]  = 27'h2AAAAAA;
    bus.req_freq[80:54] = 27'h5555555;
    bus.req_valid[0]    = 1'b1;
    wait_acc(2'd0);
    step(1);
    bus.req_valid[2] = 1'b1;
    #1;
    chk("t3_held", 32'(bus.req_ready), 0);
    wait_done();
    step(1);
    chk("t3_ready", 32'(bus.req_ready), 32'h4);
    chk("t3_idle",  32'(bus.busy), 0);
    wait_acc(2'd2);
    chk("t3_owner", 32'(bus.owner), 2);
    wait_done();
    wait_idle();

    // 4: generator never valid -> timeout
    gen_hold = 1'b1;
    dc = done_cnt;
    bus.req_freq[53:27] = 27'h0000777;
    bus.req_valid[1]    = 1'b1;
    wait_acc(2'd1);
    step(17);
    chk("t4_terr_pre", 32'(bus.timeout_err), 0);
    chk("t4_busy_pre", 32'(bus.busy), 1);
    step(1);
    chk("t4_terr", 32'(bus.timeout_err), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_nodone", 32'(done_cnt - dc), 0);
    chk("t4_sb", 32'(sb.size()), 1);
    if (sb.size() > 0) void'(sb.pop_back());
    step(3);
    chk("t4_sticky", 32'(bus.timeout_err), 1);
    gen_hold = 1'b0;
    bus.req_valid[1] = 1'b1;
    wait_acc(2'd1);
    chk("t4_clear", 32'(bus.timeout_err), 0);
    wait_done();
    wait_idle();

    // 5: reset in WAIT aborts without done
    bus.req_freq[107:81] = 27'h0333333;
    bus.req_valid[3]     = 1'b1;
    wait_acc(2'd3);
    step(3);
    dc = done_cnt;
    resetn = 1'b0;
    step(1);
    chk("t5_busy",  32'(bus.busy), 0);
    chk("t5_phrst", 32'(bus.ph_reset), 1);
    chk("t5_done",  32'(bus.done), 0);
    resetn = 1'b1;
    step(8);
    chk("t5_nodone", 32'(done_cnt - dc), 0);
    bus.req_valid[3] = 1'b1;
    wait_acc(2'd3);
    chk("t5_owner", 32'(bus.owner), 3);
    wait_done();
    wait_idle();

    // 6: phase increments by the loaded word; later req_freq changes ignored
    bus.req_freq[26:0] = 27'h0400000;
    bus.req_valid[0]   = 1'b1;
    wait_acc(2'd0);
    bus.req_freq[26:0] = 27'h0000001;
    wait_done();
    step(2);
    chk("t6_freq", 32'(bus.ph_freq), 32'h0400000);
    for (int k = 0; k < 3; k++) begin
      p0 = g_phase;
      step(1);
      p1 = g_phase;
      chk("t6_dphase", 32'(27'(p1 - p0)), 32'h0400000);
    end

    chk("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
